// File: rtl/rabb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rabb_pkg
//  Description : Shared definitions for the ray/AABB hit aggregation slice.
//                FP format of the slab-test comparator, comparator latency,
//                default aggregator sizing and the ray record layout.
//  Contents    : FP_WE/FP_WF/FP_W, exception field bounds, FPSUB_LAT,
//                RHA_* defaults, ray_rec_t
//  Revision    : 1.0 - initial release
// ============================================================================
package rabb_pkg;

   // Comparator operand format: 2-bit exception code, sign, exponent, fraction.
   localparam int FP_WE     = 11;
   localparam int FP_WF     = 21;
   localparam int FP_W      = FP_WE + FP_WF + 3;   // 35
   localparam int FP_EXC_HI = 34;
   localparam int FP_EXC_LO = 33;

   // FPSub_11_21 pipeline depth; the comparator adds one output register.
   localparam int FPSUB_LAT = 2;

   // Aggregator defaults.
   localparam int RHA_LAT    = FPSUB_LAT + 1;
   localparam int RHA_IDXW   = 4;
   localparam int RHA_FDEPTH = 4;

   // One completed ray, packed in the same bit order the FIFO stores it.
   typedef struct packed {
      logic                hit;
      logic [RHA_IDXW-1:0] first_idx;
      logic [RHA_IDXW:0]   hit_count;
   } ray_rec_t;

endpackage
`default_nettype wire

// File: rtl/ray_hit_aggregator_if.sv
`default_nettype none
// ============================================================================
//  Module      : ray_hit_aggregator_if
//  Description : Box-tag / comparator-result inputs and the ray-record
//                valid/ready output of the hit aggregator.
//  Modports    : master - upstream issue logic and traversal control
//                slave  - ray_hit_aggregator
//  Revision    : 1.0 - initial release
// ============================================================================
interface ray_hit_aggregator_if #(
   parameter int IDXW = 4
);
   logic            box_valid;
   logic [IDXW-1:0] box_idx;
   logic            box_last;
   logic            le_result;
   logic            res_valid;
   logic            res_ready;
   logic            res_hit;
   logic [IDXW-1:0] res_first_idx;
   logic [IDXW:0]   res_hit_count;
   logic            overflow;

   modport master (
      output box_valid, box_idx, box_last, le_result, res_ready,
      input  res_valid, res_hit, res_first_idx, res_hit_count, overflow
   );

   modport slave (
      input  box_valid, box_idx, box_last, le_result, res_ready,
      output res_valid, res_hit, res_first_idx, res_hit_count, overflow
   );
endinterface
`default_nettype wire

// File: rtl/rabb_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rabb_result_fifo
//  Description : Synchronous FIFO for completed ray records. Head entry is
//                read from registered storage; reads as zero when empty.
//                A push while full is only accepted if a pop happens in the
//                same cycle.
//  Ports       : clk, rst (async, active-high), push, pop, din,
//                dout (head), full, empty
//  Revision    : 1.0 - initial release
// ============================================================================
module rabb_result_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             push,
   input  wire logic             pop,
   input  wire logic [WIDTH-1:0] din,
   output logic      [WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);
   localparam int c_aw = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == (c_aw+1)'(DEPTH));
   assign w_do_pop  = pop & ~empty;
   // Full FIFO still takes a push when the head leaves in the same cycle.
   assign w_do_push = push & (~full | w_do_pop);
   assign dout      = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/ray_hit_aggregator.sv
`default_nettype none
// ============================================================================
//  Module      : ray_hit_aggregator
//  Description : Consumes the registered slab-test comparator result, realigns
//                it with the box tags issued LAT cycles earlier, folds all
//                boxes of one ray into {hit, first_idx, hit_count} and queues
//                the record for the traversal control.
//  Ports       : clk, rst (async, active-high)
//                bus.box_valid/box_idx/box_last - tags of box issued this cycle
//                bus.le_result                  - comparator hit bit
//                bus.res_valid/res_ready        - record handshake
//                bus.res_hit/res_first_idx/res_hit_count - head record
//                bus.overflow                   - sticky record-dropped flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ray_hit_aggregator
   import rabb_pkg::*;
#(
   parameter int LAT    = RHA_LAT,
   parameter int IDXW   = RHA_IDXW,
   parameter int FDEPTH = RHA_FDEPTH
) (
   input wire logic            clk,
   input wire logic            rst,
   ray_hit_aggregator_if.slave bus
);
   localparam int         c_rec_w    = 2 * IDXW + 2;
   localparam logic [0:0] c_st_idle  = 1'b0;
   localparam logic [0:0] c_st_accum = 1'b1;

   // ---------------------------------------------------------------- tag delay
   logic [LAT-1:0]  r_dl_valid;
   logic [LAT-1:0]  r_dl_last;
   logic [IDXW-1:0] r_dl_idx [LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dl_valid <= '0;
         r_dl_last  <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_dl_idx[i] <= '0;
         end
      end else begin
         r_dl_valid[0] <= bus.box_valid;
         r_dl_last[0]  <= bus.box_last;
         r_dl_idx[0]   <= bus.box_idx;
         for (int i = 1; i < LAT; i++) begin
            r_dl_valid[i] <= r_dl_valid[i-1];
            r_dl_last[i]  <= r_dl_last[i-1];
            r_dl_idx[i]   <= r_dl_idx[i-1];
         end
      end
   end

   // Last stage lines up with le_result for the same box.
   logic            w_a_valid;
   logic            w_a_last;
   logic [IDXW-1:0] w_a_idx;
   assign w_a_valid = r_dl_valid[LAT-1];
   assign w_a_last  = r_dl_last[LAT-1];
   assign w_a_idx   = r_dl_idx[LAT-1];

   // ---------------------------------------------------------------- FSM
   logic [0:0]      r_state;
   logic [0:0]      w_state_nxt;
   logic            r_acc_hit;
   logic [IDXW-1:0] r_acc_first;
   logic [IDXW:0]   r_acc_cnt;

   logic            w_base_hit;
   logic [IDXW-1:0] w_base_first;
   logic [IDXW:0]   w_base_cnt;
   logic            w_mrg_hit;
   logic [IDXW-1:0] w_mrg_first;
   logic [IDXW:0]   w_mrg_cnt;
   logic            w_acc_load;
   logic            w_push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Bubbles (no a_valid) hold the current state.
   always_comb begin
      w_state_nxt = r_state;
      if (w_a_valid) begin
         w_state_nxt = w_a_last ? c_st_idle : c_st_accum;
      end
   end

   always_comb begin
      // A box arriving in IDLE starts from an empty accumulator, so stale
      // contents from the previous ray never leak into the new one.
      w_base_hit   = 1'b0;
      w_base_first = '0;
      w_base_cnt   = '0;
      if (r_state == c_st_accum) begin
         w_base_hit   = r_acc_hit;
         w_base_first = r_acc_first;
         w_base_cnt   = r_acc_cnt;
      end
      w_mrg_hit   = w_base_hit | bus.le_result;
      w_mrg_first = w_base_hit ? w_base_first :
                    (bus.le_result ? w_a_idx : '0);
      // Saturate at 2^IDXW (MSB set) instead of wrapping.
      w_mrg_cnt   = w_base_cnt[IDXW] ? w_base_cnt :
                    w_base_cnt + {{IDXW{1'b0}}, bus.le_result};
      w_acc_load  = w_a_valid & ~w_a_last;
      w_push      = w_a_valid &  w_a_last;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_hit   <= 1'b0;
         r_acc_first <= '0;
         r_acc_cnt   <= '0;
      end else if (w_acc_load) begin
         r_acc_hit   <= w_mrg_hit;
         r_acc_first <= w_mrg_first;
         r_acc_cnt   <= w_mrg_cnt;
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [c_rec_w-1:0] w_fifo_dout;
   logic               w_full;
   logic               w_empty;
   logic               r_overflow;

   rabb_result_fifo #(
      .WIDTH (c_rec_w),
      .DEPTH (FDEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (bus.res_ready),
      .din   ({w_mrg_hit, w_mrg_first, w_mrg_cnt}),
      .dout  (w_fifo_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   // Full implies non-empty, so res_ready alone means a pop is happening.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_push & w_full & ~bus.res_ready) begin
         r_overflow <= 1'b1;
      end
   end

   assign bus.res_valid     = ~w_empty;
   assign bus.res_hit       = w_fifo_dout[c_rec_w-1];
   assign bus.res_first_idx = w_fifo_dout[c_rec_w-2 -: IDXW];
   assign bus.res_hit_count = w_fifo_dout[IDXW:0];
   assign bus.overflow      = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_ray_hit_aggregator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ray_hit_aggregator
//  Description : Directed self-checking bench for ray_hit_aggregator. A
//                three-stage shift register stands in for the comparator and
//                returns each box's hit bit LAT cycles after issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ray_hit_aggregator;
   import rabb_pkg::*;

   localparam int LAT    = 3;
   localparam int IDXW   = 4;
   localparam int FDEPTH = 4;

   logic           clk    = 1'b0;
   logic           rst    = 1'b0;
   logic           tb_hit = 1'b0;
   logic [LAT-1:0] hp     = '0;
   int             n_checks = 0;
   int             n_fail   = 0;

   ray_hit_aggregator_if #(.IDXW(IDXW)) bus ();

   ray_hit_aggregator #(
      .LAT    (LAT),
      .IDXW   (IDXW),
      .FDEPTH (FDEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Comparator stand-in: registered result LAT cycles after operands.
   always @(posedge clk) hp <= {hp[LAT-2:0], tb_hit};
   assign bus.le_result = hp[LAT-1];

   function automatic ray_rec_t mk(input logic h, input logic [3:0] f, input logic [4:0] c);
      ray_rec_t r;
      r.hit = h; r.first_idx = f; r.hit_count = c;
      return r;
   endfunction

   function automatic ray_rec_t head();
      ray_rec_t r;
      r = {bus.res_hit, bus.res_first_idx, bus.res_hit_count};
      return r;
   endfunction

   // Issue one box for exactly one clock; returns 1 time unit after the edge.
   task automatic issue(input logic [3:0] idx, input logic last, input logic hit);
      bus.box_valid = 1'b1;
      bus.box_idx   = idx;
      bus.box_last  = last;
      tb_hit        = hit;
      @(posedge clk); #1;
      bus.box_valid = 1'b0;
      bus.box_idx   = '0;
      bus.box_last  = 1'b0;
      tb_hit        = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid);
      end
      n_checks++;
      if (head() !== mk(1'b0, 4'd0, 5'd0)) begin
         n_fail++; $display("FAIL reset_record: got %h expected 000", head());
      end
      n_checks++;
      if (bus.overflow !== 1'b0) begin
         n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow);
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_ray4();
      issue(4'd0, 1'b0, 1'b0);
      issue(4'd1, 1'b0, 1'b1);
      issue(4'd2, 1'b0, 1'b0);
      issue(4'd3, 1'b1, 1'b1);
      @(posedge clk); @(posedge clk); @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b0) begin
         n_fail++; $display("FAIL ray4_early_valid: got %b expected 0 at t+LAT", bus.res_valid);
      end
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b1) begin
         n_fail++; $display("FAIL ray4_latency: got res_valid %b expected 1 at t+LAT+1", bus.res_valid);
      end
      n_checks++;
      if (head() !== mk(1'b1, 4'd1, 5'd2)) begin
         n_fail++; $display("FAIL ray4_record: got %h expected %h", head(), mk(1'b1, 4'd1, 5'd2));
      end
      pop_one();
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b0) begin
         n_fail++; $display("FAIL ray4_pop: got res_valid %b expected 0", bus.res_valid);
      end
   endtask

   task automatic test_single_miss();
      int w;
      issue(4'd5, 1'b1, 1'b0);
      w = 0;
      @(negedge clk);
      while (bus.res_valid !== 1'b1 && w < 20) begin
         @(negedge clk); w++;
      end
      n_checks++;
      if (bus.res_valid !== 1'b1) begin
         n_fail++; $display("FAIL single_timeout: got res_valid %b expected 1", bus.res_valid);
      end
      n_checks++;
      if (head() !== mk(1'b0, 4'd0, 5'd0)) begin
         n_fail++; $display("FAIL single_record: got %h expected %h", head(), mk(1'b0, 4'd0, 5'd0));
      end
      pop_one();
   endtask

   task automatic test_overflow();
      ray_rec_t exp [4];
      int       got_n;
      exp[0] = mk(1'b1, 4'd1, 5'd1);
      exp[1] = mk(1'b1, 4'd2, 5'd1);
      exp[2] = mk(1'b0, 4'd0, 5'd0);
      exp[3] = mk(1'b1, 4'd4, 5'd1);
      bus.res_ready = 1'b0;
      issue(4'd1, 1'b1, 1'b1);
      issue(4'd2, 1'b1, 1'b1);
      issue(4'd3, 1'b1, 1'b0);
      issue(4'd4, 1'b1, 1'b1);
      issue(4'd5, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.overflow !== 1'b1) begin
         n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow);
      end
      n_checks++;
      if (bus.res_valid !== 1'b1) begin
         n_fail++; $display("FAIL ovf_valid: got %b expected 1", bus.res_valid);
      end
      bus.res_ready = 1'b1;
      got_n = 0;
      for (int c = 0; c < 20 && got_n < 5; c++) begin
         if (bus.res_valid === 1'b1) begin
            n_checks++;
            if (got_n >= 4) begin
               n_fail++; $display("FAIL ovf_extra_record: got %h expected none", head());
            end else if (head() !== exp[got_n]) begin
               n_fail++; $display("FAIL ovf_drain_%0d: got %h expected %h", got_n, head(), exp[got_n]);
            end
            got_n++;
         end
         @(negedge clk);
      end
      bus.res_ready = 1'b0;
      n_checks++;
      if (got_n !== 4) begin
         n_fail++; $display("FAIL ovf_drain_count: got %0d expected 4", got_n);
      end
      n_checks++;
      if (bus.overflow !== 1'b1) begin
         n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      issue(4'd9, 1'b1, 1'b1);
      w = 0;
      @(negedge clk);
      while (bus.res_valid !== 1'b1 && w < 20) begin
         @(negedge clk); w++;
      end
      n_checks++;
      if (bus.res_valid !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_pre_valid: got %b expected 1", bus.res_valid);
      end
      @(posedge clk); #1;
      issue(4'd2, 1'b0, 1'b1);
      issue(4'd3, 1'b1, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b0 || bus.overflow !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_flags: got valid %b overflow %b expected 0 0",
                            bus.res_valid, bus.overflow);
      end
      n_checks++;
      if (head() !== mk(1'b0, 4'd0, 5'd0)) begin
         n_fail++; $display("FAIL rstmid_record: got %h expected 000", head());
      end
      @(posedge clk); #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_aborted_ray: got res_valid %b expected 0", bus.res_valid);
      end
   endtask

   task automatic test_push_pop_full();
      ray_rec_t exp [4];
      int       got_n;
      exp[0] = mk(1'b1, 4'd7,  5'd1);
      exp[1] = mk(1'b1, 4'd8,  5'd1);
      exp[2] = mk(1'b1, 4'd9,  5'd1);
      exp[3] = mk(1'b1, 4'd10, 5'd1);
      bus.res_ready = 1'b0;
      issue(4'd6,  1'b1, 1'b1);
      issue(4'd7,  1'b1, 1'b1);
      issue(4'd8,  1'b1, 1'b1);
      issue(4'd9,  1'b1, 1'b1);
      issue(4'd10, 1'b1, 1'b1);
      // Fourth record lands at the second edge below; the fifth arrives on
      // the third edge, which is the only one with res_ready high.
      @(posedge clk);
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.overflow !== 1'b0) begin
         n_fail++; $display("FAIL pp_overflow: got %b expected 0", bus.overflow);
      end
      n_checks++;
      if (head() !== exp[0]) begin
         n_fail++; $display("FAIL pp_head: got %h expected %h", head(), exp[0]);
      end
      bus.res_ready = 1'b1;
      got_n = 0;
      for (int c = 0; c < 20 && got_n < 5; c++) begin
         if (bus.res_valid === 1'b1) begin
            n_checks++;
            if (got_n >= 4) begin
               n_fail++; $display("FAIL pp_extra_record: got %h expected none", head());
            end else if (head() !== exp[got_n]) begin
               n_fail++; $display("FAIL pp_drain_%0d: got %h expected %h", got_n, head(), exp[got_n]);
            end
            got_n++;
         end
         @(negedge clk);
      end
      bus.res_ready = 1'b0;
      n_checks++;
      if (got_n !== 4) begin
         n_fail++; $display("FAIL pp_drain_count: got %0d expected 4", got_n);
      end
   endtask

   task automatic test_ray16();
      int w;
      for (int i = 0; i < 16; i++) begin
         issue(4'(i), (i == 15), 1'b1);
         if (i < 15) begin
            repeat (i % 3) begin
               @(posedge clk); #1;
            end
         end
      end
      w = 0;
      @(negedge clk);
      while (bus.res_valid !== 1'b1 && w < 20) begin
         @(negedge clk); w++;
      end
      n_checks++;
      if (bus.res_valid !== 1'b1) begin
         n_fail++; $display("FAIL ray16_timeout: got res_valid %b expected 1", bus.res_valid);
      end
      n_checks++;
      if (head() !== mk(1'b1, 4'd0, 5'd16)) begin
         n_fail++; $display("FAIL ray16_record: got %h expected %h", head(), mk(1'b1, 4'd0, 5'd16));
      end
      pop_one();
   endtask

   initial begin
      bus.box_valid = 1'b0;
      bus.box_idx   = '0;
      bus.box_last  = 1'b0;
      bus.res_ready = 1'b0;
      test_reset();
      test_ray4();
      test_single_miss();
      test_overflow();
      test_reset_mid();
      test_push_pop_full();
      test_ray16();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
